// File: rtl/fixed_point_scaler_pkg.sv
// Shared widths, operand typedefs and the saturation helper for fixed_point_scaler.
// Saturation is used only when FIXEDPOINTSCALER_SAT_EN is defined.
package fixed_point_scaler_pkg;

  localparam int unsigned DefaultBa = 27;
  localparam int unsigned DefaultBb = 16;
  localparam int unsigned DefaultBc = 27;
  localparam int unsigned DefaultBd = 27;
  localparam int unsigned DefaultBp = 45;

  // Wide enough to hold any intermediate sum for realistic widths.
  localparam int unsigned SatW = 128;

  typedef logic signed [DefaultBa-1:0]           preadd_t;
  typedef logic signed [DefaultBa+DefaultBb:0]   prod_t;
  typedef logic signed [DefaultBp-1:0]           out_t;
  typedef logic signed [SatW-1:0]                sat_t;

  // Clamp x to the w-bit signed range [-2^(w-1), 2^(w-1)-1].
  function automatic sat_t saturate(input sat_t x, input int unsigned w);
    sat_t hi;
    sat_t lo;
    hi = (sat_t'(1) <<< (w - 1)) - sat_t'(1);
    lo = ~hi;
    if (x > hi) begin
      return hi;
    end else if (x < lo) begin
      return lo;
    end
    return x;
  endfunction

endpackage

// File: rtl/fps_preadd_mult.sv
// First two pipeline stages of fixed_point_scaler: input register, wrapping pre-adder
// register, and the exact signed product driven from the second stage.
module fps_preadd_mult
  import fixed_point_scaler_pkg::*;
#(
  parameter int unsigned BA = DefaultBa,
  parameter int unsigned BB = DefaultBb,
  parameter int unsigned BC = DefaultBc,
  parameter int unsigned BD = DefaultBd
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic signed [BA-1:0]   a_i,
  input  logic signed [BB-1:0]   b_i,
  input  logic signed [BC-1:0]   c_i,
  input  logic signed [BD-1:0]   d_i,
  output logic signed [BA+BB:0]  m_o,
  output logic signed [BC-1:0]   c_o
);

  localparam int unsigned PW = BA + BB + 1;

  logic signed [BA-1:0] a_d, a_q;
  logic signed [BB-1:0] b_d, b_q;
  logic signed [BC-1:0] c_d, c_q;
  logic signed [BD-1:0] d_d, d_q;
  logic signed [BA-1:0] s_d, s_q;
  logic signed [BB-1:0] b2_d, b2_q;
  logic signed [BC-1:0] c2_d, c2_q;

  always_comb begin
    a_d  = a_i;
    b_d  = b_i;
    c_d  = c_i;
    d_d  = d_i;
    // d is resized to BA bits and the sum wraps at BA bits.
    s_d  = a_q + BA'(d_q);
    b2_d = b_q;
    c2_d = c_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      a_q  <= '0;
      b_q  <= '0;
      c_q  <= '0;
      d_q  <= '0;
      s_q  <= '0;
      b2_q <= '0;
      c2_q <= '0;
    end else begin
      a_q  <= a_d;
      b_q  <= b_d;
      c_q  <= c_d;
      d_q  <= d_d;
      s_q  <= s_d;
      b2_q <= b2_d;
      c2_q <= c2_d;
    end
  end

  assign m_o = PW'(s_q) * PW'(b2_q);
  assign c_o = c2_q;

endmodule

// File: rtl/fixed_point_scaler.sv
// Pipelined signed scaler p = (a + d) * b + c, three register stages.
// Define FIXEDPOINTSCALER_SAT_EN to saturate p instead of wrapping it.
module fixed_point_scaler
  import fixed_point_scaler_pkg::*;
#(
  parameter int unsigned BA = DefaultBa,
  parameter int unsigned BB = DefaultBb,
  parameter int unsigned BC = DefaultBc,
  parameter int unsigned BD = DefaultBd,
  parameter int unsigned BP = DefaultBp
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic signed [BA-1:0]  a,
  input  logic signed [BB-1:0]  b,
  input  logic signed [BC-1:0]  c,
  input  logic signed [BD-1:0]  d,
  output logic signed [BP-1:0]  p
);

  localparam int unsigned PW  = BA + BB + 1;
  localparam int unsigned RW0 = ((PW > BC) ? PW : BC) + 1;
  localparam int unsigned RW  = (RW0 > BP) ? RW0 : BP;

  logic signed [PW-1:0] m;
  logic signed [BC-1:0] c_s2;
  logic signed [RW-1:0] r;
  logic signed [BP-1:0] p_d, p_q;

  fps_preadd_mult #(
    .BA(BA),
    .BB(BB),
    .BC(BC),
    .BD(BD)
  ) u_preadd_mult (
    .clk_i (clk),
    .rst_ni(clr),
    .a_i   (a),
    .b_i   (b),
    .c_i   (c),
    .d_i   (d),
    .m_o   (m),
    .c_o   (c_s2)
  );

  always_comb begin
    // Lossless post-add; the narrowing to BP happens only below.
    r = RW'(m) + RW'(c_s2);
`ifdef FIXEDPOINTSCALER_SAT_EN
    p_d = BP'(saturate(SatW'(r), BP));
`else
    p_d = BP'(r);
`endif
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      p_q <= '0;
    end else begin
      p_q <= p_d;
    end
  end

  assign p = p_q;

endmodule

// File: tb/tb_fixed_point_scaler.sv
// Directed and random checks of fixed_point_scaler: latency, reset, wrap and saturation.
module tb_fixed_point_scaler;
  import fixed_point_scaler_pkg::*;

  logic               clk;
  logic               clr;
  logic signed [26:0] a, c, d;
  logic signed [15:0] b;
  logic signed [44:0] p;
  logic signed [19:0] p20;

  int n_vec = 0;
  int n_err = 0;

  fixed_point_scaler dut (
    .clk(clk), .clr(clr), .a(a), .b(b), .c(c), .d(d), .p(p)
  );

  fixed_point_scaler #(.BP(20)) dut20 (
    .clk(clk), .clr(clr), .a(a), .b(b), .c(c), .d(d), .p(p20)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input longint got, input longint exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic drive(input longint va, input longint vb, input longint vc, input longint vd);
    a = 27'(va);
    b = 16'(vb);
    c = 27'(vc);
    d = 27'(vd);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic longint model(input logic signed [26:0] fa, input logic signed [15:0] fb,
                                   input logic signed [26:0] fc, input logic signed [26:0] fd);
    preadd_t s;
    prod_t   m;
    out_t    o;
    s = fa + fd;
    m = prod_t'(s) * prod_t'(fb);
    o = out_t'(longint'(m) + longint'(fc));
    return longint'(o);
  endfunction

  initial begin
    clr = 1'b0;
    drive(0, 1, 0, 0);
    #12;
    check_eq("reset_p", p, 0);
    check_eq("reset_p20", p20, 0);
    clr = 1'b1;

    // Basic function
    step(3); check_eq("b1", p, 0);
    a = 1;   step(3); check_eq("a1", p, 1);
    a = 2;   step(3); check_eq("a2", p, 2);
    b = 2;   step(3); check_eq("b2", p, 4);
    c = 1;   step(3); check_eq("c1", p, 5);
    d = 1;   step(3); check_eq("d1", p, 7);

    // Signed operands
    drive(-5, -3, -10, 2);       step(3); check_eq("signed1", p, -1);
    drive(1000, 7, 500, -3000);  step(3); check_eq("signed2", p, -13500);

    // Pre-adder wrap
    drive(67108863, 1, 0, 1);    step(3); check_eq("wrap_pos", p, -67108864);
    drive(67108863, -1, 0, 1);   step(3); check_eq("wrap_neg", p, 67108864);

    // Extremes
    drive(-67108864, -32768, 0, -67108864);     step(3); check_eq("ext_zero", p, 0);
    drive(-67108864, -32768, 67108863, 0);      step(3);
    check_eq("ext_max", p, 64'sd2199023255552 + 64'sd67108863);

    for (int i = 0; i < 20; i++) begin
      a = 27'($urandom);
      b = 16'($urandom);
      c = 27'($urandom);
      d = 27'($urandom);
      step(4);
      check_eq($sformatf("rand%0d", i), p, model(a, b, c, d));
    end

    // Latency: single-cycle pulse
    drive(0, 0, 0, 0); step(4); check_eq("lat_pre", p, 0);
    drive(3, 4, 0, 0); step(1);
    drive(0, 0, 0, 0); check_eq("lat_e1", p, 0);
    step(1); check_eq("lat_e2", p, 0);
    step(1); check_eq("lat_e3", p, 12);
    step(1); check_eq("lat_e4", p, 0);

    // Asynchronous reset mid-operation
    drive(5, 5, 0, 0); step(3); check_eq("pre_clr", p, 25);
    #2 clr = 1'b0;
    #1 check_eq("clr_async", p, 0);
    #2 clr = 1'b1;
    step(1); check_eq("rel_e1", p, 0);
    step(1); check_eq("rel_e2", p, 0);
    step(1); check_eq("rel_e3", p, 25);

    // Narrow output: saturate or wrap
    drive(67108863, 32767, 0, 0); step(3);
    check_eq("wide_out", p, 64'sd2198956113921);
`ifdef FIXEDPOINTSCALER_SAT_EN
    check_eq("bp20_sat", p20, 524287);
`else
    check_eq("bp20_wrap", p20, -32767);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
